// File: rtl/dualsyncram_be.sv
// Two-write / two-read synchronous RAM with per-byte write enables,
// port-B-wins write collisions, optional write-to-read forwarding and an
// optional post-reset clear engine that zeroes every word before ready.
module dualsyncram_be #(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 8,
  parameter int BYPASS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AWIDTH-1:0]   a_waddr,
  input  logic [DWIDTH-1:0]   a_wdata,
  input  logic [DWIDTH/8-1:0] a_be,
  input  logic [AWIDTH-1:0]   b_waddr,
  input  logic [DWIDTH-1:0]   b_wdata,
  input  logic [DWIDTH/8-1:0] b_be,
  input  logic [AWIDTH-1:0]   a_raddr,
  output logic [DWIDTH-1:0]   a_rdata,
  input  logic [AWIDTH-1:0]   b_raddr,
  output logic [DWIDTH-1:0]   b_rdata,
  output logic                ready
);

  localparam int LANES = DWIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] cnt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wr_en;
  logic [DWIDTH-1:0] a_fwd;
  logic [DWIDTH-1:0] b_fwd;

  // User writes are honoured only once the RAM reports ready and not on a reset edge.
  assign wr_en = ready & ~reset;

  // Control: clear sweep after reset, then permanent RUN; ready is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + AWIDTH'(1);
          if (cnt == '1) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  // Storage: clear-engine writes, else byte-lane writes with port B applied last so it wins.
  always_ff @(posedge clk) begin
    if (!reset && state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (a_be[i]) mem[a_waddr][8*i +: 8] <= a_wdata[8*i +: 8];
        if (b_be[i]) mem[b_waddr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
  end

  // Read-side word: old contents, or the merged post-write word when forwarding.
  always_comb begin
    a_fwd = mem[a_raddr];
    b_fwd = mem[b_raddr];
    if (BYPASS != 0 && wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (a_be[i] && a_waddr == a_raddr) a_fwd[8*i +: 8] = a_wdata[8*i +: 8];
        if (b_be[i] && b_waddr == a_raddr) a_fwd[8*i +: 8] = b_wdata[8*i +: 8];
        if (a_be[i] && a_waddr == b_raddr) b_fwd[8*i +: 8] = a_wdata[8*i +: 8];
        if (b_be[i] && b_waddr == b_raddr) b_fwd[8*i +: 8] = b_wdata[8*i +: 8];
      end
    end
  end

  // Registered read data, held at zero whenever the RAM is not ready.
  always_ff @(posedge clk) begin
    if (reset || !ready) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= a_fwd;
      b_rdata <= b_fwd;
    end
  end

endmodule

// File: tb/tb_dualsyncram_be.sv
// Scoreboard bench for dualsyncram_be: a BYPASS=0 and a BYPASS=1 instance share
// stimulus and are compared against an array-based reference model; a third
// instance without the clear engine is checked for ready timing.
module tb_dualsyncram_be;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] a_waddr, b_waddr, a_raddr, b_raddr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [1:0]    a_be, b_be;
  logic [DW-1:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1, a_rdata2, b_rdata2;
  logic          ready0, ready1, ready2;

  always #5 clk = ~clk;

  dualsyncram_be #(.DWIDTH(DW), .AWIDTH(AW), .BYPASS(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset),
    .a_waddr(a_waddr), .a_wdata(a_wdata), .a_be(a_be),
    .b_waddr(b_waddr), .b_wdata(b_wdata), .b_be(b_be),
    .a_raddr(a_raddr), .a_rdata(a_rdata0),
    .b_raddr(b_raddr), .b_rdata(b_rdata0),
    .ready(ready0)
  );

  dualsyncram_be #(.DWIDTH(DW), .AWIDTH(AW), .BYPASS(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset),
    .a_waddr(a_waddr), .a_wdata(a_wdata), .a_be(a_be),
    .b_waddr(b_waddr), .b_wdata(b_wdata), .b_be(b_be),
    .a_raddr(a_raddr), .a_rdata(a_rdata1),
    .b_raddr(b_raddr), .b_rdata(b_rdata1),
    .ready(ready1)
  );

  dualsyncram_be #(.DWIDTH(DW), .AWIDTH(AW), .BYPASS(0), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset(reset),
    .a_waddr(a_waddr), .a_wdata(a_wdata), .a_be(a_be),
    .b_waddr(b_waddr), .b_wdata(b_wdata), .b_be(b_be),
    .a_raddr(a_raddr), .a_rdata(a_rdata2),
    .b_raddr(b_raddr), .b_rdata(b_rdata2),
    .ready(ready2)
  );

  typedef struct {
    logic [DW-1:0] a0, b0, a1, b1;
    logic          rdy, rdy2;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [16];
  logic          m_ready  = 1'b0;
  logic          m_ready2 = 1'b0;
  int            m_left   = 16;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Predict the outcome of the coming posedge from the current inputs and push it.
  task automatic step();
    exp_t          e;
    logic [DW-1:0] nm [16];
    e.a0 = '0; e.b0 = '0; e.a1 = '0; e.b1 = '0;
    if (reset) begin
      m_ready  = 1'b0;
      m_ready2 = 1'b0;
      m_left   = 16;
    end else begin
      m_ready2 = 1'b1;
      if (!m_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_ready = 1'b1;
          for (int k = 0; k < 16; k++) m_mem[k] = '0;
        end
      end else begin
        nm = m_mem;
        for (int i = 0; i < 2; i++) begin
          if (a_be[i]) nm[a_waddr][8*i +: 8] = a_wdata[8*i +: 8];
          if (b_be[i]) nm[b_waddr][8*i +: 8] = b_wdata[8*i +: 8];
        end
        e.a0 = m_mem[a_raddr];
        e.b0 = m_mem[b_raddr];
        e.a1 = nm[a_raddr];
        e.b1 = nm[b_raddr];
        m_mem = nm;
      end
    end
    e.rdy  = m_ready;
    e.rdy2 = m_ready2;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic rst,
                     input logic [AW-1:0] aw, input logic [DW-1:0] ad, input logic [1:0] abe,
                     input logic [AW-1:0] bw, input logic [DW-1:0] bd, input logic [1:0] bbe,
                     input logic [AW-1:0] ar, input logic [AW-1:0] br);
    reset   = rst;
    a_waddr = aw; a_wdata = ad; a_be = abe;
    b_waddr = bw; b_wdata = bd; b_be = bbe;
    a_raddr = ar; b_raddr = br;
    step();
    @(negedge clk);
  endtask

  task automatic rand_cyc();
    logic [AW-1:0] aw, bw, ar, br;
    bit            narrow;
    narrow = ($urandom_range(0, 1) == 1);
    aw = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
    bw = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
    case ($urandom_range(0, 3))
      0:       ar = aw;
      1:       ar = bw;
      default: ar = AW'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       br = bw;
      1:       br = aw;
      2:       br = ar;
      default: br = AW'($urandom);
    endcase
    cyc(1'b0, aw, DW'($urandom), 2'($urandom), bw, DW'($urandom), 2'($urandom), ar, br);
  endtask

  // Monitor: every cycle the DUTs present read data and ready; compare with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ready0",   {15'd0, ready0}, {15'd0, e.rdy});
        chk("ready1",   {15'd0, ready1}, {15'd0, e.rdy});
        chk("ready2",   {15'd0, ready2}, {15'd0, e.rdy2});
        chk("a_rdata0", a_rdata0, e.a0);
        chk("b_rdata0", b_rdata0, e.b0);
        chk("a_rdata1", a_rdata1, e.a1);
        chk("b_rdata1", b_rdata1, e.b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cnt;
    // Reset, then clear sweep with writes attempted (addr 3 BEEF must be ignored)
    cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) cyc(1'b0, 3, 16'hBEEF, 2'b11, 4'd3, 16'hBEEF, 2'b11, 3, 3);
      else        rand_cyc();
    end
    // Read every address after clear
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 0, 0, 0, 0, 0, AW'(i), AW'(15 - i));
    // Partial byte write
    cyc(1'b0, 5, 16'h1234, 2'b11, 0, 0, 2'b00, 0, 0);
    cyc(1'b0, 5, 16'hAB00, 2'b10, 0, 0, 2'b00, 0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 5, 5);
    // Collision: B wins lane 0, A keeps lane 1
    cyc(1'b0, 7, 16'h1111, 2'b11, 7, 16'h2222, 2'b01, 0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 7, 7);
    // Same-cycle read/write hit
    cyc(1'b0, 9, 16'h5A5A, 2'b11, 0, 0, 2'b00, 9, 9);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 9, 9);
    // Random traffic
    for (int i = 0; i < 400; i++) rand_cyc();
    // Mid-clear reset restarts the sweep
    cyc(1'b0, 2, 16'hCAFE, 2'b11, 0, 0, 2'b00, 2, 2);
    cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) rand_cyc();
    cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) rand_cyc();
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 2, 2);
    for (int i = 0; i < 100; i++) rand_cyc();
    // Drain the scoreboard with a bounded wait
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0 pending", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
